reg_op_arbiter: RTL and testbench
=================================

# reg_op_arbiter

Sequencer and two-port arbiter for a shared 4-bit control register (cl/ld/inc/dec/sr/ir/sl/il strobe interface). Two requesters submit operations. The block grants them round-robin and drives the register's strobes for one or more cycles per operation. Multi-cycle shift and rotate ops are expanded here, so requesters see a single req/gnt/done transaction.

## Interface
- `W`, default 4: register data width; fixed at 4 for this register.
- `clk  input  1  system clock, rising edge`
- `rst_n  input  1  reset; synchronous, active-low`
- `req0 / req1  input  1  request; held high with op/arg stable until gnt`
- `op0 / op1  input  3  opcode: 0 CLR, 1 LOAD, 2 INC, 3 DEC, 4 SHR, 5 SHL, 6 ROR, 7 ROL`
- `arg0 / arg1  input  4  LOAD data, or shift count minus one in bits [1:0]`
- `gnt0 / gnt1  output  1  one-cycle acceptance pulse`
- `done0 / done1  output  1  one-cycle pulse in the last strobe cycle of the op`
- `reg_q  input  4  current register output, used for rotate fill`
- `cl, ld, inc, dec, sr, sl  output  1  register strobes; at most one is high at a time`
- `ir, il  output  1  shift fill bits`
- `reg_in  output  4  load data`
- `busy  output  1  high while in EXEC`

## Operation
- FSM with 2 states.
  - IDLE: no strobes asserted.
  - EXEC: drives the latched op.
- **Arbitration in IDLE**
  - If exactly one req is high, that requester is granted.
  - If both are high, the requester that was not granted last wins.
  - The `last` pointer resets to 1, so req0 wins the first tie.
  - `gnt` is a combinational pulse in the IDLE cycle in which the req is seen.
  - In the same cycle the block latches op, arg and the owner, updates `last`, and moves to EXEC.
- **EXEC**
  - Drives exactly one strobe per cycle. `reg_in` carries the latched arg during LOAD and is 0 otherwise.
  - CLR, LOAD, INC and DEC take 1 cycle.
  - SHR, SHL, ROR and ROL take N = arg[1:0]+1 cycles, tracked by a 2-bit down-counter.
  - SHR and SHL fill with 0.
  - `done<owner>` is high in the final EXEC cycle. The next edge returns the FSM to IDLE.
- Requests are ignored in EXEC: no preemption, and gnt stays low.
- **Outputs in IDLE:** all strobes are 0, ir = il = 0, and busy = 0.

## Timing
- Grant at cycle T puts the first strobe in cycle T+1. The register updates at the edge that ends T+1.
- Throughput:
  - A single-cycle op occupies 2 cycles (IDLE + EXEC).
  - An N-step shift occupies N+1 cycles.
  - A back-to-back request always has one IDLE bubble.
- The strobes, `reg_in` and `done` are decoded from registered state. ir/il are combinational from `reg_q` only when rotating.
- **Reset values:** after the first rising edge with rst_n = 0, the state is IDLE, the counter is 0, `last` is 1, and every output is 0.
- **Reset mid-op:** the op is aborted with no done pulse and the strobes are 0 from the next cycle.
  - A req still held after release is granted in the first IDLE cycle, following normal priority.
- **Dropped req:** dropping req before gnt is legal and loses the request. Changing op/arg while req is high and not yet granted is illegal.

## Configuration
- Macro: `REG_OP_ARBITER_ROTATE_EN`.
- **Defined:**
  - ROR drives sr with ir = reg_q[0] each step.
  - ROL drives sl with il = reg_q[3] each step.
- **Undefined:**
  - Opcodes 6 and 7 execute exactly as SHR and SHL with zero fill.
  - The `reg_q` input is unused; the port remains present.

## Structure
- Package `reg_op_pkg` contains:
  - the opcode enum `reg_op_e` (3 bits, values above);
  - the state enum `arb_state_e` {IDLE, EXEC};
  - localparam `SHCNT_W = 2`.
- Sub-module `rr_arb2`: a 2-way round-robin arbiter.
  - Inputs: req[1:0], update enable.
  - Outputs: one-hot gnt[1:0].
  - Holds the `last` pointer with a synchronous active-low reset.

## Test plan
- After reset, req0 LOAD arg 4'hA: gnt0 in cycle 0; ld = 1 and reg_in = A in cycle 1 with done0 = 1; register = 4'hA; busy 1 only in cycle 1.
- req0 INC and req1 DEC held together from the first cycle after reset, register at 4'h5:
  - gnt0 first, inc cycle; then one IDLE bubble; then gnt1, dec cycle.
  - Register ends at 4'h5. A third tie goes to req0.
- Register 4'b1000, req1 SHR arg 2'd2: sr high for 3 consecutive cycles with ir = 0; done1 only in the 3rd; register = 4'b0001.
- Register 4'b0001, ROR arg 0: with the macro, ir = 1 and the register becomes 4'b1000. Without the macro, the register becomes 4'b0000.
- Register 4'hF, ROL arg 3: with the macro, 4 sl steps and the register is still 4'hF. Without it, the register becomes 4'h0.
- rst_n low in the 2nd cycle of a 4-step SHL, with req1 held:
  - next cycle all strobes are 0, busy = 0, and no done pulse occurs.
  - After release, gnt1 is asserted in the first cycle.

Source files
------------

// File: rtl/reg_op_arbiter_pkg.sv
// Shared types for the control-register sequencer: opcode and FSM encodings.
package reg_op_pkg;

  localparam int unsigned SHCNT_W = 2;

  typedef enum logic [2:0] {
    OpClr  = 3'd0,
    OpLoad = 3'd1,
    OpInc  = 3'd2,
    OpDec  = 3'd3,
    OpShr  = 3'd4,
    OpShl  = 3'd5,
    OpRor  = 3'd6,
    OpRol  = 3'd7
  } reg_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } arb_state_e;

  // Opcodes 4..7 are the multi-cycle shift/rotate group.
  function automatic logic is_multi_op(reg_op_e op);
    return op[2];
  endfunction

endpackage

// File: rtl/reg_op_arbiter_if.sv
// Requester handshakes plus register strobe bus for reg_op_arbiter.
interface reg_op_arbiter_if #(
  parameter int unsigned W = 4
);
  logic         req0, req1;
  logic [2:0]   op0, op1;
  logic [W-1:0] arg0, arg1;
  logic         gnt0, gnt1;
  logic         done0, done1;
  logic [W-1:0] reg_q;
  logic         cl, ld, inc, dec, sr, sl;
  logic         ir, il;
  logic [W-1:0] reg_in;
  logic         busy;

  modport master (
    output req0, req1, op0, op1, arg0, arg1, reg_q,
    input  gnt0, gnt1, done0, done1, cl, ld, inc, dec, sr, sl, ir, il, reg_in, busy
  );

  modport slave (
    input  req0, req1, op0, op1, arg0, arg1, reg_q,
    output gnt0, gnt1, done0, done1, cl, ld, inc, dec, sr, sl, ir, il, reg_in, busy
  );
endinterface

// File: rtl/reg_op_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; last_q remembers the most recent winner.
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       upd_i,
  output logic [1:0] gnt_o
);

  logic last_q, last_d;

  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

  always_comb begin
    last_d = last_q;
    if (upd_i && (|gnt_o)) begin
      last_d = gnt_o[1];
    end
  end

  // Resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/reg_op_arbiter.sv
// Two-port arbiter and op sequencer for a 4-bit strobe-controlled register.
// Define REG_OP_ARBITER_ROTATE_EN to make opcodes 6/7 true rotates.
module reg_op_arbiter
  import reg_op_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input logic             clk,
  input logic             rst_n,
  reg_op_arbiter_if.slave bus
);

  arb_state_e         state_q, state_d;
  reg_op_e            op_q, op_d;
  logic [W-1:0]       arg_q, arg_d;
  logic               owner_q, owner_d;
  logic [SHCNT_W-1:0] cnt_q, cnt_d;

  logic [1:0] arb_req, arb_gnt;
  logic       arb_upd;
  logic       last_step;

  // Requests only reach the arbiter in IDLE and outside reset.
  assign arb_req   = {bus.req1, bus.req0} & {2{rst_n && (state_q == IDLE)}};
  assign arb_upd   = rst_n && (state_q == IDLE);
  assign last_step = (cnt_q == '0);

  rr_arb2 u_rr_arb2 (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .req_i  (arb_req),
    .upd_i  (arb_upd),
    .gnt_o  (arb_gnt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= OpClr;
      arg_q   <= '0;
      owner_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      arg_q   <= arg_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    arg_d   = arg_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (|arb_gnt) begin
          owner_d = arb_gnt[1];
          op_d    = reg_op_e'(arb_gnt[1] ? bus.op1 : bus.op0);
          arg_d   = arb_gnt[1] ? bus.arg1 : bus.arg0;
          cnt_d   = is_multi_op(op_d) ? arg_d[SHCNT_W-1:0] : '0;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (last_step) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - SHCNT_W'(1);
        end
      end
    endcase
  end

  always_comb begin
    bus.gnt0   = arb_gnt[0];
    bus.gnt1   = arb_gnt[1];
    bus.busy   = (state_q == EXEC);
    bus.done0  = 1'b0;
    bus.done1  = 1'b0;
    bus.cl     = 1'b0;
    bus.ld     = 1'b0;
    bus.inc    = 1'b0;
    bus.dec    = 1'b0;
    bus.sr     = 1'b0;
    bus.sl     = 1'b0;
    bus.ir     = 1'b0;
    bus.il     = 1'b0;
    bus.reg_in = '0;
    if (state_q == EXEC) begin
      bus.done0 = last_step & ~owner_q;
      bus.done1 = last_step & owner_q;
      unique case (op_q)
        OpClr:  bus.cl  = 1'b1;
        OpLoad: begin
          bus.ld     = 1'b1;
          bus.reg_in = arg_q;
        end
        OpInc:  bus.inc = 1'b1;
        OpDec:  bus.dec = 1'b1;
        OpShr:  bus.sr  = 1'b1;
        OpShl:  bus.sl  = 1'b1;
        OpRor: begin
          bus.sr = 1'b1;
`ifdef REG_OP_ARBITER_ROTATE_EN
          bus.ir = bus.reg_q[0];
`endif
        end
        OpRol: begin
          bus.sl = 1'b1;
`ifdef REG_OP_ARBITER_ROTATE_EN
          bus.il = bus.reg_q[W-1];
`endif
        end
      endcase
    end
  end

`ifndef REG_OP_ARBITER_ROTATE_EN
  // Rotate fill is disabled, so the register feedback is intentionally unused.
  logic unused_reg_q;
  assign unused_reg_q = ^bus.reg_q;
`endif

endmodule

// File: tb/tb_reg_op_arbiter.sv
// Directed plus randomized bench for reg_op_arbiter against a behavioural register model.
module tb_reg_op_arbiter;

`ifdef REG_OP_ARBITER_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  reg_op_arbiter_if #(.W(4)) bus ();

  reg_op_arbiter #(.W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Plant: the controlled register, reacting to whatever strobes the DUT drives.
  logic [3:0] plant_q;
  logic       preset_en;
  logic [3:0] preset_val;
  assign bus.reg_q = plant_q;

  always_ff @(posedge clk) begin
    if (preset_en)   plant_q <= preset_val;
    else if (bus.cl)  plant_q <= 4'h0;
    else if (bus.ld)  plant_q <= bus.reg_in;
    else if (bus.inc) plant_q <= plant_q + 4'h1;
    else if (bus.dec) plant_q <= plant_q - 4'h1;
    else if (bus.sr)  plant_q <= {bus.ir, plant_q[3:1]};
    else if (bus.sl)  plant_q <= {plant_q[2:0], bus.il};
  end

  int n_checks = 0;
  int n_errors = 0;
  int last_w   = 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] ref_result(input logic [2:0] op, input logic [3:0] arg,
                                            input logic [3:0] v);
    int n;
    n = int'(arg[1:0]) + 1;
    case (op)
      3'd0:    return 4'h0;
      3'd1:    return arg;
      3'd2:    return v + 4'h1;
      3'd3:    return v - 4'h1;
      3'd4:    return v >> n;
      3'd5:    return v << n;
      3'd6:    return ROT ? ((v >> n) | (v << (4 - n))) : (v >> n);
      default: return ROT ? ((v << n) | (v >> (4 - n))) : (v << n);
    endcase
  endfunction

  function automatic int ref_len(input logic [2:0] op, input logic [3:0] arg);
    return (op >= 3'd4) ? int'(arg[1:0]) + 1 : 1;
  endfunction

  // {cl, ld, inc, dec, sr, sl}
  function automatic logic [5:0] exp_strobe(input logic [2:0] op);
    case (op)
      3'd0:       return 6'b100000;
      3'd1:       return 6'b010000;
      3'd2:       return 6'b001000;
      3'd3:       return 6'b000100;
      3'd4, 3'd6: return 6'b000010;
      default:    return 6'b000001;
    endcase
  endfunction

  function automatic logic [5:0] strobes();
    return {bus.cl, bus.ld, bus.inc, bus.dec, bus.sr, bus.sl};
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic preset(input logic [3:0] v);
    preset_en  = 1'b1;
    preset_val = v;
    tick();
    preset_en  = 1'b0;
  endtask

  task automatic idle_checks(input string tag);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_strobes"}, 32'({strobes(), bus.ir, bus.il}), 32'd0);
    chk({tag, "_done"}, 32'({bus.done1, bus.done0}), 32'd0);
    chk({tag, "_reg_in"}, 32'(bus.reg_in), 32'd0);
  endtask

  // Called at the sample point of the grant cycle; returns at the following IDLE cycle.
  task automatic exec_phase(input int p, input logic [2:0] op, input logic [3:0] arg);
    int         n;
    logic [3:0] v;
    n = ref_len(op, arg);
    v = ref_result(op, arg, plant_q);
    @(negedge clk);
    if (p == 0) bus.req0 = 1'b0;
    else        bus.req1 = 1'b0;
    #1;
    for (int i = 0; i < n; i++) begin
      if (i > 0) tick();
      chk("exec_busy", 32'(bus.busy), 32'd1);
      chk("exec_strobe", 32'(strobes()), 32'(exp_strobe(op)));
      chk("exec_reg_in", 32'(bus.reg_in), (op == 3'd1) ? 32'(arg) : 32'd0);
      chk("exec_ir", 32'(bus.ir), (ROT && op == 3'd6) ? 32'(plant_q[0]) : 32'd0);
      chk("exec_il", 32'(bus.il), (ROT && op == 3'd7) ? 32'(plant_q[3]) : 32'd0);
      chk("exec_no_gnt", 32'({bus.gnt1, bus.gnt0}), 32'd0);
      chk("exec_done", 32'({bus.done1, bus.done0}),
          (i == n - 1) ? (p == 1 ? 32'd2 : 32'd1) : 32'd0);
    end
    tick();
    idle_checks("post");
    chk("result", 32'(plant_q), 32'(v));
  endtask

  task automatic grant(input int p, input logic [2:0] op, input logic [3:0] arg);
    if (p == 0) begin
      bus.op0 = op; bus.arg0 = arg; bus.req0 = 1'b1;
    end else begin
      bus.op1 = op; bus.arg1 = arg; bus.req1 = 1'b1;
    end
    #1;
    chk("gnt", 32'({bus.gnt1, bus.gnt0}), (p == 1) ? 32'd2 : 32'd1);
    last_w = p;
  endtask

  task automatic tie(input logic [2:0] o0, input logic [3:0] a0,
                     input logic [2:0] o1, input logic [3:0] a1);
    int w;
    w = (last_w == 1) ? 0 : 1;
    bus.op0 = o0; bus.arg0 = a0; bus.op1 = o1; bus.arg1 = a1;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    #1;
    chk("tie_gnt", 32'({bus.gnt1, bus.gnt0}), (w == 1) ? 32'd2 : 32'd1);
    last_w = w;
    exec_phase(w, (w == 1) ? o1 : o0, (w == 1) ? a1 : a0);
    chk("tie_second_gnt", 32'({bus.gnt1, bus.gnt0}), (w == 1) ? 32'd1 : 32'd2);
    last_w = 1 - w;
    exec_phase(1 - w, (w == 1) ? o0 : o1, (w == 1) ? a0 : a1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    idle_checks("reset");
    chk("reset_gnt", 32'({bus.gnt1, bus.gnt0}), 32'd0);
    rst_n  = 1'b1;
    last_w = 1;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.op0 = 3'd0; bus.op1 = 3'd0; bus.arg0 = 4'h0; bus.arg1 = 4'h0;
    preset_en = 1'b1; preset_val = 4'h0;
    tick();
    preset_en = 1'b0;
    do_reset();

    // LOAD straight after reset.
    grant(0, 3'd1, 4'hA);
    exec_phase(0, 3'd1, 4'hA);

    // Held tie INC/DEC from the first cycle after reset, then a third tie.
    preset(4'h5);
    do_reset();
    tie(3'd2, 4'h0, 3'd3, 4'h0);
    chk("tie_reg", 32'(plant_q), 32'h5);
    tie(3'd0, 4'h0, 3'd1, 4'h3);

    // SHR by 3 on req1.
    preset(4'b1000);
    grant(1, 3'd4, 4'd2);
    exec_phase(1, 3'd4, 4'd2);

    // ROR by 1 and ROL by 4.
    preset(4'b0001);
    grant(0, 3'd6, 4'd0);
    exec_phase(0, 3'd6, 4'd0);
    preset(4'hF);
    grant(1, 3'd7, 4'd3);
    exec_phase(1, 3'd7, 4'd3);

    // Reset in the second step of a 4-step SHL with req1 still held.
    preset(4'b0110);
    grant(1, 3'd5, 4'd3);
    tick();
    chk("abort_c1_done", 32'({bus.done1, bus.done0}), 32'd0);
    tick();
    chk("abort_c2_sl", 32'(bus.sl), 32'd1);
    rst_n = 1'b0;
    tick();
    idle_checks("abort");
    chk("abort_gnt_in_reset", 32'({bus.gnt1, bus.gnt0}), 32'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    last_w = 1;
    #1;
    chk("abort_regrant", 32'({bus.gnt1, bus.gnt0}), 32'd2);
    exec_phase(1, 3'd5, 4'd3);

    // Random single requests and ties with idle gaps.
    for (int k = 0; k < 30; k++) begin
      logic [2:0] o0, o1;
      logic [3:0] a0, a1;
      o0 = 3'($urandom_range(0, 7)); a0 = 4'($urandom_range(0, 15));
      o1 = 3'($urandom_range(0, 7)); a1 = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) begin
        tie(o0, a0, o1, a1);
      end else if ($urandom_range(0, 1) == 0) begin
        grant(0, o0, a0);
        exec_phase(0, o0, a0);
      end else begin
        grant(1, o1, a1);
        exec_phase(1, o1, a1);
      end
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
